// File: rtl/uart1_tx_port.sv
// UART1 transmit peripheral: register file, byte TX FIFO and an 8N1 serializer.
// state | meaning: IDLE = line idle, waiting for data; START = start bit; DATA = 8 data bits, LSB first; STOP = stop bit.
module uart1_tx_port #(
    parameter int N            = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int BAUD_DIV_RST = 868
) (
    input  logic         clk,
    input  logic         nRESET,
    input  logic         UART1,
    input  logic [11:0]  address,
    input  logic         read,
    input  logic         write,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         tx,
    output logic         tx_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [9:0] A_TXDATA  = 10'h000;
    localparam logic [9:0] A_STATUS  = 10'h001;
    localparam logic [9:0] A_BAUDDIV = 10'h002;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   baud_div;
    logic [15:0]   div_act;
    logic [15:0]   baud_cnt;
    logic          overflow;
    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;

    logic          access_wr;
    logic          access_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          baud_tick;
    logic [15:0]   div_wr;
    logic [3:0]    count_4;
    logic [N-1:0]  rd_mux;
    logic          unused_bits;

    assign unused_bits = ^{wdata[N-1:16], address[1:0]};

    assign access_wr  = UART1 & write;
    assign access_rd  = UART1 & read & ~write;
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_req   = access_wr & (address[11:2] == A_TXDATA);
    assign baud_tick  = (baud_cnt == div_act - 16'd1);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign pop        = ((state == S_IDLE) | ((state == S_STOP) & baud_tick)) & ~fifo_empty;
    assign push       = push_req & (~fifo_full | pop);
    assign div_wr     = (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
    assign count_4    = 4'(count);

    always_comb begin
        rd_mux = '0;
        case (address[11:2])
            A_STATUS:  rd_mux[7:0]  = {count_4, overflow, tx_busy, fifo_empty, fifo_full};
            A_BAUDDIV: rd_mux[15:0] = baud_div;
            default:   rd_mux       = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            rdata    <= '0;
            baud_div <= 16'(BAUD_DIV_RST);
            overflow <= 1'b0;
        end else begin
            if (access_rd) begin
                rdata <= rd_mux;
            end
            if (access_wr && address[11:2] == A_BAUDDIV) begin
                baud_div <= div_wr;
            end
            if (access_wr && address[11:2] == A_STATUS) begin
                overflow <= 1'b0;
            end else if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // tx follows the state one cycle late, so every state period maps to exactly div line cycles.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state    <= S_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            div_act  <= 16'(BAUD_DIV_RST);
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_busy <= (state != S_IDLE) | ~fifo_empty;
            case (state)
                S_START: tx <= 1'b0;
                S_DATA:  tx <= shift[0];
                default: tx <= 1'b1;
            endcase

            if (state == S_IDLE || baud_tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end

            if (pop) begin
                shift   <= fifo_mem[rd_ptr];
                div_act <= baud_div;
                state   <= S_START;
            end else if (baud_tick) begin
                case (state)
                    S_START: begin
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                    S_DATA: begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                    S_STOP:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart1_tx_port.sv
// Scoreboard bench for uart1_tx_port: expected reads and frames are queued by stimulus, popped by monitors.
module tb_uart1_tx_port;
    localparam int N = 32;
    localparam logic [11:0] A_TXDATA  = 12'h000;
    localparam logic [11:0] A_STATUS  = 12'h004;
    localparam logic [11:0] A_BAUDDIV = 12'h008;

    logic         clk     = 1'b0;
    logic         nRESET  = 1'b0;
    logic         UART1   = 1'b0;
    logic [11:0]  address = '0;
    logic         read    = 1'b0;
    logic         write   = 1'b0;
    logic [N-1:0] wdata   = '0;
    logic [N-1:0] rdata;
    logic         tx;
    logic         tx_busy;

    uart1_tx_port #(.N(N), .FIFO_DEPTH(4), .BAUD_DIV_RST(868)) dut (
        .clk     (clk),
        .nRESET  (nRESET),
        .UART1   (UART1),
        .address (address),
        .read    (read),
        .write   (write),
        .wdata   (wdata),
        .rdata   (rdata),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
        int         start;
    } frame_t;

    frame_t       frame_q[$];
    logic [N-1:0] rd_q[$];
    logic [N-1:0] last_rd = '0;
    int           tests    = 0;
    int           fails    = 0;
    int           cyc      = 0;
    int           last_end = -1;
    bit           mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic acc(bit u, bit r, bit w, logic [11:0] a, logic [N-1:0] d);
        UART1 = u; read = r; write = w; address = a; wdata = d;
        @(negedge clk);
        UART1 = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic rd(logic [11:0] a, logic [N-1:0] exp);
        rd_q.push_back(exp);
        last_rd = exp;
        acc(1'b1, 1'b1, 1'b0, a, '0);
    endtask

    // Read strobe that must not update rdata (unselected, or write wins).
    task automatic rd_hold(bit u, bit w, logic [11:0] a, logic [N-1:0] d);
        rd_q.push_back(last_rd);
        acc(u, 1'b1, w, a, d);
    endtask

    task automatic wr(logic [11:0] a, logic [N-1:0] d);
        acc(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic send(logic [7:0] b, int div, bit b2b, bit timed);
        frame_t f;
        f.data  = b;
        f.div   = div;
        f.b2b   = b2b;
        f.start = timed ? cyc + 3 : -1;
        frame_q.push_back(f);
        acc(1'b1, 1'b0, 1'b1, A_TXDATA, N'(b));
    endtask

    task automatic wait_idle(int limit);
        int n = 0;
        while ((tx_busy !== 1'b0 || frame_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
        end
    endtask

    // Read monitor: every read strobe has a queued expectation for rdata.
    initial begin : read_mon
        forever begin
            @(posedge clk);
            if (nRESET && read) begin
                #1;
                if (rd_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected: rdata 0x%0h, required no read", rdata);
                end else begin
                    check("rdata", rdata, rd_q.pop_front());
                end
            end
        end
    end

    // Frame monitor: a low tx starts a frame; every line cycle is compared to the expected 8N1 waveform.
    initial begin : frame_mon
        frame_t f;
        int     bad;
        int     bi;
        bit     expb;
        bit     aborted;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                if (frame_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: tx low at cycle %0d, required idle high", cyc);
                    while (tx === 1'b0) @(negedge clk);
                end else begin
                    f = frame_q.pop_front();
                    bad = 0;
                    aborted = 1'b0;
                    if (f.start >= 0) check("frame_start", cyc, f.start);
                    if (f.b2b) check("frame_gap", cyc, last_end);
                    for (int i = 0; i < 10 * f.div; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!mon_en) begin
                            aborted = 1'b1;
                            break;
                        end
                        bi = i / f.div;
                        expb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : f.data[bi-1];
                        if (tx !== expb) bad++;
                    end
                    if (!aborted) begin
                        check("frame_bits_bad", bad, 0);
                        last_end = cyc + 1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation timed out");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int t0;
        int n;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_rdata", rdata, 0);
        check("rst_busy", tx_busy, 0);
        nRESET = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        rd(A_STATUS, 32'h2);
        rd(A_BAUDDIV, 32'd868);
        rd(A_TXDATA, 32'h0);
        rd(12'h00C, 32'h0);
        rd(12'h006, 32'h2);

        // Single frame at div=4.
        wr(A_BAUDDIV, 32'd4);
        rd(A_BAUDDIV, 32'd4);
        t0 = cyc + 3;
        send(8'hA5, 4, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        n = 0;
        while (tx_busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall", cyc, t0 + 40);
        wait_idle(100);

        // Back-to-back burst, fill and overflow.
        wr(A_BAUDDIV, 32'd2);
        send(8'h11, 2, 1'b0, 1'b1);
        send(8'h12, 2, 1'b1, 1'b0);
        send(8'h13, 2, 1'b1, 1'b0);
        send(8'h14, 2, 1'b1, 1'b0);
        send(8'h15, 2, 1'b1, 1'b0);
        rd(A_STATUS, 32'h45);
        acc(1'b1, 1'b0, 1'b1, A_TXDATA, 32'h16);
        rd(A_STATUS, 32'h4D);
        wr(A_STATUS, 32'h0);
        rd(A_STATUS, 32'h45);
        wait_idle(400);
        rd(A_STATUS, 32'h2);

        // Divisor clamping and mid-frame divisor change.
        wr(A_BAUDDIV, 32'd1);
        rd(A_BAUDDIV, 32'd2);
        wr(A_BAUDDIV, 32'd0);
        rd(A_BAUDDIV, 32'd2);
        wr(A_BAUDDIV, 32'hFFFF_0003);
        rd(A_BAUDDIV, 32'd3);
        wr(A_BAUDDIV, 32'd2);
        send(8'h3C, 2, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        wr(A_BAUDDIV, 32'd8);
        send(8'hC3, 8, 1'b1, 1'b0);
        rd(A_BAUDDIV, 32'd8);
        wait_idle(400);

        // Unselected accesses and read+write collision.
        rd_hold(1'b0, 1'b0, A_STATUS, '0);
        acc(1'b0, 1'b0, 1'b1, A_TXDATA, 32'h55);
        repeat (40) @(negedge clk);
        check("nosel_busy", tx_busy, 0);
        check("nosel_tx", tx, 1);
        rd(A_STATUS, 32'h2);
        rd_hold(1'b1, 1'b1, A_BAUDDIV, 32'd20);
        rd(A_BAUDDIV, 32'd20);

        // Reset mid-DATA with three bytes queued.
        wr(A_BAUDDIV, 32'd4);
        send(8'h81, 4, 1'b0, 1'b1);
        send(8'h82, 4, 1'b1, 1'b0);
        send(8'h83, 4, 1'b1, 1'b0);
        send(8'h84, 4, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("pre_rst_tx_data", tx, 0);
        #2;
        mon_en = 1'b0;
        frame_q.delete();
        nRESET = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_rdata", rdata, 0);
        last_rd = '0;
        repeat (2) @(negedge clk);
        nRESET = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        rd(A_STATUS, 32'h2);
        rd(A_BAUDDIV, 32'd868);
        repeat (200) @(negedge clk);
        check("post_rst_busy", tx_busy, 0);

        repeat (3) @(negedge clk);
        check("frames_left", frame_q.size(), 0);
        check("reads_left", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
